flag_reg_dec: RTL and testbench

- Flag register plus branch-condition decoder for the ONC-16 CPU.
- Captures the ALU status flags every cycle into a flag register.
- Decodes a 4-bit condition code (func) against the registered flags.
- Asserts is_br when a branch is enabled (bre) and the condition holds; is_br drives PC-select in the fetch stage.

---
 rtl/flag_reg_dec_pkg.sv | 31 +++
 rtl/flag_reg_dec_br_cond_dec.sv | 41 ++++
 rtl/flag_reg_dec.sv | 32 +++
 tb/tb_flag_reg_dec.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flag_reg_dec_pkg.sv
// Shared constants for the ONC-16 flag register and branch-condition decoder:
// widths, flag bit positions and condition-code encodings.
package flag_reg_dec_pkg;

  localparam int FR_FLAG_W = 4;
  localparam int FR_FUNC_W = 4;

  // Flag bit positions inside the {V,C,N,Z} status word
  localparam int FR_Z = 0;
  localparam int FR_N = 1;
  localparam int FR_C = 2;
  localparam int FR_V = 3;

  localparam logic [FR_FUNC_W-1:0] CC_EQ = 4'd0;
  localparam logic [FR_FUNC_W-1:0] CC_NE = 4'd1;
  localparam logic [FR_FUNC_W-1:0] CC_CS = 4'd2;
  localparam logic [FR_FUNC_W-1:0] CC_CC = 4'd3;
  localparam logic [FR_FUNC_W-1:0] CC_MI = 4'd4;
  localparam logic [FR_FUNC_W-1:0] CC_PL = 4'd5;
  localparam logic [FR_FUNC_W-1:0] CC_VS = 4'd6;
  localparam logic [FR_FUNC_W-1:0] CC_VC = 4'd7;
  localparam logic [FR_FUNC_W-1:0] CC_HI = 4'd8;
  localparam logic [FR_FUNC_W-1:0] CC_LS = 4'd9;
  localparam logic [FR_FUNC_W-1:0] CC_GE = 4'd10;
  localparam logic [FR_FUNC_W-1:0] CC_LT = 4'd11;
  localparam logic [FR_FUNC_W-1:0] CC_GT = 4'd12;
  localparam logic [FR_FUNC_W-1:0] CC_LE = 4'd13;
  localparam logic [FR_FUNC_W-1:0] CC_AL = 4'd14;
  localparam logic [FR_FUNC_W-1:0] CC_NV = 4'd15;

endpackage

// File: rtl/flag_reg_dec_br_cond_dec.sv
// Combinational branch-condition decoder: evaluates a condition code
// against a {V,C,N,Z} flag word.
module br_cond_dec
  import flag_reg_dec_pkg::*;
(
  input  logic [FR_FUNC_W-1:0] func,
  input  logic [FR_FLAG_W-1:0] fr,
  output logic                 cond
);

  logic z, n, c, v;

  assign z = fr[FR_Z];
  assign n = fr[FR_N];
  assign c = fr[FR_C];
  assign v = fr[FR_V];

  always_comb begin
    cond = 1'b0;
    case (func)
      CC_EQ:   cond = z;
      CC_NE:   cond = ~z;
      CC_CS:   cond = c;
      CC_CC:   cond = ~c;
      CC_MI:   cond = n;
      CC_PL:   cond = ~n;
      CC_VS:   cond = v;
      CC_VC:   cond = ~v;
      CC_HI:   cond = c & ~z;
      CC_LS:   cond = ~c | z;
      CC_GE:   cond = ~(n ^ v);
      CC_LT:   cond = n ^ v;
      CC_GT:   cond = ~z & ~(n ^ v);
      CC_LE:   cond = z | (n ^ v);
      CC_AL:   cond = 1'b1;
      CC_NV:   cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_reg_dec.sv
// ONC-16 flag register plus branch decision: ALU flags are captured every
// cycle and the registered copy is decoded against func, gated by bre.
module flag_reg_dec
  import flag_reg_dec_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic [FR_FLAG_W-1:0] flags,
  input  logic [FR_FUNC_W-1:0] func,
  input  logic                 bre,
  output logic                 is_br
);

  logic [FR_FLAG_W-1:0] fr;
  logic                 cond;

  // Clear wins over the load on the same edge; no write enable by design
  always_ff @(posedge clock) begin
    if (rst) fr <= '0;
    else     fr <= flags;
  end

  br_cond_dec u_br_cond_dec (
    .func (func),
    .fr   (fr),
    .cond (cond)
  );

  // func and bre are unregistered so PC-select sees them in the same cycle
  assign is_br = bre & cond;

endmodule

// File: tb/tb_flag_reg_dec.sv
// Directed bench for flag_reg_dec: reset, exhaustive func x flags sweeps,
// latency, mid-sweep reset and the combinational func path.
module tb_flag_reg_dec;

  logic       clock;
  logic       rst;
  logic [3:0] flags;
  logic [3:0] func;
  logic       bre;
  logic       is_br;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  flag_reg_dec dut (
    .clock (clock),
    .rst   (rst),
    .flags (flags),
    .func  (func),
    .bre   (bre),
    .is_br (is_br)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference condition table, {V,C,N,Z}
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] fl);
    logic z, n, c, v;
    z = fl[0]; n = fl[1]; c = fl[2]; v = fl[3];
    case (f)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver: step to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flags = 4'hF; bre = 1'b1; func = 4'd0;
    tick();
    rst = 1'b0;
    func = 4'd0; #1;
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL reset_eq is_br=%b exp=0", is_br); end
    func = 4'd1; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL reset_ne is_br=%b exp=1", is_br); end
    func = 4'd14; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL reset_al is_br=%b exp=1", is_br); end
  endtask

  task automatic test_sweep(input logic bre_v);
    logic [0:0] exp;
    for (int f = 0; f < 16; f++) begin
      for (int fl = 0; fl < 16; fl++) begin
        tick();
        flags = 4'(fl); func = 4'(f); bre = bre_v;
        exp_q.push_back(bre_v & ref_cond(4'(f), 4'(fl)));
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (is_br !== exp[0]) begin
          errors++;
          $display("FAIL sweep bre=%b func=%0d flags=%b is_br=%b exp=%b",
                   bre_v, f, 4'(fl), is_br, exp[0]);
        end
      end
    end
  endtask

  task automatic test_examples();
    logic [3:0] fl_v [3];
    logic [3:0] fn_v [3];
    fl_v[0] = 4'b0001; fn_v[0] = 4'd0;
    fl_v[1] = 4'b1000; fn_v[1] = 4'd11;
    fl_v[2] = 4'b1010; fn_v[2] = 4'd10;
    bre = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flags = fl_v[i]; func = fn_v[i];
      tick();
      checks++;
      if (is_br !== 1'b1) begin
        errors++;
        $display("FAIL example%0d func=%0d flags=%b is_br=%b exp=1", i, fn_v[i], fl_v[i], is_br);
      end
    end
  endtask

  task automatic test_latency();
    bre = 1'b1; func = 4'd0; flags = 4'b0000;
    tick();
    flags = 4'b0001; #1;
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL lat_before_edge is_br=%b exp=0", is_br); end
    tick();
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL lat_n1 is_br=%b exp=1", is_br); end
    flags = 4'b0000; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL lat_hold is_br=%b exp=1", is_br); end
    tick();
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL lat_n2 is_br=%b exp=0", is_br); end
  endtask

  task automatic test_reset_mid();
    bre = 1'b1;
    for (int fl = 0; fl < 4; fl++) begin
      flags = 4'(fl + 8); func = 4'd11;
      tick();
      checks++;
      if (is_br !== ref_cond(4'd11, 4'(fl + 8))) begin
        errors++; $display("FAIL mid_pre fl=%0d is_br=%b", fl + 8, is_br);
      end
    end
    rst = 1'b1; flags = 4'hF;
    tick();
    func = 4'd0; #1;
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL mid_rst_eq is_br=%b exp=0", is_br); end
    func = 4'd1; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL mid_rst_ne is_br=%b exp=1", is_br); end
    rst = 1'b0;
    tick();
    func = 4'd0; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL mid_reload_eq is_br=%b exp=1", is_br); end
    func = 4'd12; #1;
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL mid_reload_gt is_br=%b exp=0", is_br); end
    for (int fl = 4; fl < 8; fl++) begin
      flags = 4'(fl); func = 4'd8;
      tick();
      checks++;
      if (is_br !== ref_cond(4'd8, 4'(fl))) begin
        errors++; $display("FAIL mid_resume fl=%0d is_br=%b", fl, is_br);
      end
    end
  endtask

  task automatic test_comb_func();
    bre = 1'b1; flags = 4'b0100;
    tick();
    func = 4'd2; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL comb_cs is_br=%b exp=1", is_br); end
    func = 4'd3; #1;
    checks++;
    if (is_br !== 1'b0) begin errors++; $display("FAIL comb_cc is_br=%b exp=0", is_br); end
    func = 4'd2; #1;
    checks++;
    if (is_br !== 1'b1) begin errors++; $display("FAIL comb_cs2 is_br=%b exp=1", is_br); end
  endtask

  initial begin
    rst = 1'b1; flags = 4'h0; func = 4'd0; bre = 1'b0;
    test_reset();
    test_sweep(1'b1);
    test_sweep(1'b0);
    test_examples();
    test_latency();
    test_reset_mid();
    test_comb_func();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
